// File: rtl/car_detector_if.sv
// ---------------------------------------------------------------------------
// car_detector_if
//   Signal bundle between a road junction controller / sensor front end and
//   the car_detector block.
//
//   sense1, sense2 : raw loop sensors (asynchronous, high while a car is present)
//   lightseq[5:0]  : junction lights {R1, A1, G1, R2, A2, G2}
//   D1, D2         : registered "cars waiting" requests per road
//   wait1, wait2   : registered waiting-car counts per road
//
//   There is no valid/ready handshake on this bundle. Every signal is a
//   level that is sampled or updated on each rising clock edge.
//
//   modport master : drives the sensors and lights, observes the results
//   modport slave  : the detector itself
// ---------------------------------------------------------------------------
interface car_detector_if #(
  parameter int CNT_W = 4
);
  logic             sense1;
  logic             sense2;
  logic [5:0]       lightseq;
  logic             D1;
  logic             D2;
  logic [CNT_W-1:0] wait1;
  logic [CNT_W-1:0] wait2;

  modport master (
    output sense1, sense2, lightseq,
    input  D1, D2, wait1, wait2
  );

  modport slave (
    input  sense1, sense2, lightseq,
    output D1, D2, wait1, wait2
  );
endinterface

// File: rtl/car_detector.sv
// ---------------------------------------------------------------------------
// car_detector
//   Counts vehicles queuing at a two-road junction. Each road's raw loop
//   sensor is synchronised and then debounced. Every debounced 0->1 edge
//   produces one arrival pulse, and each arrival adds one to that road's
//   waiting count. The count saturates at its maximum value and clears on
//   any cycle in which that road's green light is on.
//
//   Ports
//     clock     : system clock, rising edge
//     reset     : asynchronous, active-low
//     bus.slave : sense1/sense2 and lightseq in; D1/D2 and wait1/wait2 out
//
//   Parameters
//     DEBOUNCE : stable synchronised cycles needed to accept a level change (1..15)
//     CNT_W    : width of each waiting counter
//
//   Road 1 uses array index 0 and road 2 uses index 1. The two roads share
//   no state.
// ---------------------------------------------------------------------------
module car_detector #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic           clock,
  input  logic           reset,
  car_detector_if.slave  bus
);

  localparam int               DCW      = 4;
  localparam logic [DCW-1:0]   DEB_LAST = DCW'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = {CNT_W{1'b1}};

  logic [1:0] w_sense;
  logic [1:0] w_green;

  assign w_sense = {bus.sense2, bus.sense1};
  // Only the green bits matter. Amber and red never touch the counters.
  assign w_green = {bus.lightseq[0], bus.lightseq[3]};

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_deb;
  logic [1:0]       r_arr;
  logic [1:0]       r_req;
  logic [DCW-1:0]   r_dcnt [2];
  logic [CNT_W-1:0] r_wait [2];
  logic [CNT_W-1:0] w_wait_nxt [2];

  // Next waiting count. Green takes priority over a coincident arrival.
  // The request flag is derived from this value so that it is registered on
  // the same edge as the count.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_wait_nxt[i] = r_wait[i];
      if (w_green[i]) begin
        w_wait_nxt[i] = '0;
      end else if (r_arr[i] && (r_wait[i] != WAIT_MAX)) begin
        w_wait_nxt[i] = r_wait[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_arr   <= '0;
      r_req   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dcnt[i] <= '0;
        r_wait[i] <= '0;
      end
    end else begin
      r_sync1 <= w_sense;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_arr[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (r_dcnt[i] == DEB_LAST) begin
          // This is the DEBOUNCE-th consecutive differing sample, so the
          // new level is accepted now. The arrival pulse is raised on the
          // same edge, but only for a rising edge of the debounced level.
          r_deb[i]  <= ~r_deb[i];
          r_dcnt[i] <= '0;
          r_arr[i]  <= ~r_deb[i];
        end else begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end
        r_wait[i] <= w_wait_nxt[i];
        r_req[i]  <= (w_wait_nxt[i] != '0);
      end
    end
  end

  assign bus.D1    = r_req[0];
  assign bus.D2    = r_req[1];
  assign bus.wait1 = r_wait[0];
  assign bus.wait2 = r_wait[1];

endmodule

// File: tb/tb_car_detector.sv
// ---------------------------------------------------------------------------
// tb_car_detector
//   Directed scenarios followed by a randomised phase. All of them are checked
//   against a reference model. In the model, a sensor change is accepted once
//   the last DEBOUNCE synchronised samples all disagree with the accepted
//   level.
// ---------------------------------------------------------------------------
module tb_car_detector;

  localparam int DEB   = 4;
  localparam int CW    = 4;
  localparam int W_MAX = (1 << CW) - 1;

  logic clock;
  logic reset;

  car_detector_if #(.CNT_W(CW)) bus ();

  car_detector #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- counters ----------------
  int n_checks = 0;
  int n_err    = 0;
  string phase = "reset";

  // ---------------- reference model ----------------
  bit [1:0]  m_rh   [2];  // raw samples from the last two edges, oldest in bit 1
  bit [15:0] m_sh   [2];  // synchronised sample history, newest in bit 0
  bit        m_deb  [2];
  bit        m_arr  [2];
  int        m_wait [2];

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_rh[r]   = '0;
      m_sh[r]   = '0;
      m_deb[r]  = 1'b0;
      m_arr[r]  = 1'b0;
      m_wait[r] = 0;
    end
  endtask

  task automatic model_edge();
    bit [15:0] mask;
    bit        raw;
    bit        green;
    bit        s;
    mask = 16'((1 << DEB) - 1);
    for (int r = 0; r < 2; r++) begin
      raw   = (r == 0) ? bus.sense1 : bus.sense2;
      green = (r == 0) ? bus.lightseq[3] : bus.lightseq[0];
      // The waiting count reacts to the arrival seen on the previous edge.
      if (green) m_wait[r] = 0;
      else if (m_arr[r]) m_wait[r] = (m_wait[r] < W_MAX) ? m_wait[r] + 1 : W_MAX;
      s        = m_rh[r][1];
      m_rh[r]  = {m_rh[r][0], raw};
      m_sh[r]  = {m_sh[r][14:0], s};
      m_arr[r] = 1'b0;
      if (((m_sh[r] ^ {16{m_deb[r]}}) & mask) == mask) begin
        m_arr[r] = ~m_deb[r];
        m_deb[r] = s;
        m_sh[r]  = {16{s}};
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s observed=%0d expected=%0d", phase, tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("wait1", int'(bus.wait1), m_wait[0]);
    check("wait2", int'(bus.wait2), m_wait[1]);
    check("D1", int'(bus.D1), int'(m_wait[0] != 0));
    check("D2", int'(bus.D2), int'(m_wait[1] != 0));
  endtask

  // ---------------- driver tasks ----------------
  // Runs one clock edge. The model advances from the same input values, and
  // the outputs are compared shortly after the edge.
  task automatic step();
    @(posedge clock);
    if (reset) model_edge();
    #1;
    check_model();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input int road, input int hi, input int lo);
    if (road == 1) bus.sense1 = 1'b1; else bus.sense2 = 1'b1;
    steps(hi);
    if (road == 1) bus.sense1 = 1'b0; else bus.sense2 = 1'b0;
    steps(lo);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hold1;
    int hold2;
    logic [5:0] ls;

    reset        = 1'b0;
    bus.sense1   = 1'b0;
    bus.sense2   = 1'b0;
    bus.lightseq = 6'b100100;
    model_reset();
    #1;
    check_model();
    steps(2);
    release_reset();

    // A held sensor must raise D1 after exactly edge DEB+3.
    phase = "latency";
    bus.sense1 = 1'b1;
    steps(DEB + 2);
    check("D1_early", int'(bus.D1), 0);
    step();
    check("D1_edge7", int'(bus.D1), 1);
    check("wait1_edge7", int'(bus.wait1), 1);
    check("D2_idle", int'(bus.D2), 0);
    bus.sense1 = 1'b0;
    steps(8);

    // A pulse shorter than DEB must be ignored.
    phase = "glitch";
    pulse(2, 3, 12);
    check("wait2_glitch", int'(bus.wait2), 0);
    check("D2_glitch", int'(bus.D2), 0);

    // Count five cars, then clear the count with a single green cycle.
    phase = "count5";
    bus.lightseq = 6'b001100;
    step();
    bus.lightseq = 6'b100100;
    for (int p = 0; p < 5; p++) pulse(1, 8, 8);
    check("wait1_five", int'(bus.wait1), 5);
    bus.lightseq = 6'b001100;
    step();
    check("wait1_green", int'(bus.wait1), 0);
    check("D1_green", int'(bus.D1), 0);
    bus.lightseq = 6'b100100;

    // The count saturates at its maximum instead of wrapping.
    phase = "saturate";
    for (int p = 0; p < 20; p++) pulse(2, 8, 8);
    check("wait2_sat", int'(bus.wait2), W_MAX);
    check("D2_sat", int'(bus.D2), 1);

    // Arrivals while green is on are discarded.
    phase = "green_hold";
    bus.lightseq = 6'b100001;
    pulse(2, 8, 8);
    check("wait2_green", int'(bus.wait2), 0);

    // Green and the arrival pulse land on the same edge: green wins.
    phase = "coincide";
    bus.lightseq = 6'b100100;
    bus.sense2   = 1'b1;
    steps(DEB + 2);
    bus.lightseq = 6'b100001;
    step();
    check("wait2_coinc", int'(bus.wait2), 0);
    check("D2_coinc", int'(bus.D2), 0);
    bus.lightseq = 6'b100100;
    steps(4);
    check("wait2_after", int'(bus.wait2), 0);
    bus.sense2 = 1'b0;
    steps(8);

    // Reset in mid-count discards all progress, then counting resumes.
    phase = "midreset";
    for (int p = 0; p < 3; p++) pulse(1, 8, 8);
    check("wait1_three", int'(bus.wait1), 3);
    bus.sense1 = 1'b1;
    steps(2);
    reset = 1'b0;
    model_reset();
    #1;
    check("wait1_async", int'(bus.wait1), 0);
    check("D1_async", int'(bus.D1), 0);
    check_model();
    steps(2);
    release_reset();
    steps(DEB + 2);
    check("D1_rst_early", int'(bus.D1), 0);
    step();
    check("wait1_rst", int'(bus.wait1), 1);
    check("D1_rst", int'(bus.D1), 1);
    bus.sense1 = 1'b0;
    steps(8);

    // Random sensor activity. Green is rare; amber and red bits vary freely.
    phase = "random";
    hold1 = 0;
    hold2 = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold1 == 0) begin
        bus.sense1 = 1'($urandom_range(0, 1));
        hold1 = $urandom_range(1, 10);
      end
      if (hold2 == 0) begin
        bus.sense2 = 1'($urandom_range(0, 1));
        hold2 = $urandom_range(1, 10);
      end
      hold1--;
      hold2--;
      ls = 6'($urandom);
      if ($urandom_range(0, 39) != 0) ls[3] = 1'b0;
      if ($urandom_range(0, 39) != 0) ls[0] = 1'b0;
      bus.lightseq = ls;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/car_detector.md
CAR_DETECTOR -- requirements
Module: car_detector

Interface
REQ-001 Parameter DEBOUNCE, default 4: consecutive stable cycles needed to accept a sensor level change; legal range 1..15.
REQ-002 Parameter CNT_W, default 4: width of each waiting-car counter.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 sense1  input  1  raw road-1 loop sensor, asynchronous to clock, high while a vehicle is present.
REQ-006 sense2  input  1  raw road-2 loop sensor, same properties as sense1.
REQ-007 lightseq  input  6  junction light state: [5]=R1, [4]=A1, [3]=G1, [2]=R2, [1]=A2, [0]=G2.
REQ-008 D1  output  1  registered road-1 request: high while one or more road-1 vehicles are waiting.
REQ-009 D2  output  1  registered road-2 request: high while one or more road-2 vehicles are waiting.
REQ-010 wait1  output  CNT_W  registered count of road-1 vehicles waiting.
REQ-011 wait2  output  CNT_W  registered count of road-2 vehicles waiting.

Function
REQ-012 Each sense input SHALL pass through a 2-flop synchroniser before any other logic.
REQ-013 Per road, a debounced level (deb) and a counter (0..DEBOUNCE) SHALL be held.
- Counter increments each cycle that the synchronised level differs from deb.
- Counter clears to 0 on any cycle where the synchronised level equals deb.
- When the counter reaches DEBOUNCE, deb toggles and the counter clears.
REQ-014 A sensor pulse held for fewer than DEBOUNCE synchronised cycles SHALL NOT change deb; falling edges obey the same rule.
REQ-015 An arrival event SHALL be a registered single-cycle pulse generated on each 0->1 transition of deb; 1->0 transitions generate nothing.
REQ-016 Per road, the waiting counter SHALL update as follows (road 1 uses lightseq[3], road 2 uses lightseq[0]):
- Clears to 0 on every cycle that the road's green bit is 1.
- Otherwise increments by 1 on each arrival event.
- Saturates at 2^CNT_W-1 and never wraps.
REQ-017 If an arrival event and the road's green bit coincide in the same cycle, green SHALL win and the counter SHALL be 0 after the edge.
REQ-018 D1 SHALL equal (wait1 != 0), D2 SHALL equal (wait2 != 0); both are registered together with the counters, with no extra cycle of skew.
REQ-019 Roads SHALL be fully independent; simultaneous events on both roads SHALL each be processed in the same cycle.
REQ-020 Latency: with sense held high from before rising edge 1, D SHALL go high after edge DEBOUNCE+3 (edge 7 at default), provided that road's green bit is 0.
REQ-021 Amber and red bits SHALL NOT affect the counters; only the green bits clear requests.
REQ-022 Implementation SHALL be 4 state elements per road (2 sync flops, deb, debounce counter) plus the arrival pulse register and the wait counter; no latches, no combinational output paths.

Reset
REQ-023 When reset=0, all of the following SHALL asynchronously clear to 0 and remain 0 until reset is released: synchronisers, deb, debounce counters, arrival pulses, wait1, wait2, D1, D2.
REQ-024 Reset asserted mid-debounce or mid-count SHALL discard all progress.
- After release, a sensor still held high SHALL be treated as a fresh 0->1 change.
- That change produces one arrival after DEBOUNCE+3 edges.
REQ-025 Operation SHALL resume on the first rising edge after reset returns to 1.

Verification
REQ-026 lightseq=6'b100100, sense1 0->1 held -> D1=1 and wait1=1 after edge 7; D2=0 and wait2=0 throughout.
REQ-027 sense2 pulsed high for 3 cycles, then low (DEBOUNCE=4) -> D2 stays 0 and wait2 stays 0.
REQ-028 Five clean sense1 pulses (each 8 cycles high, 8 low) with lightseq=6'b100100 -> wait1=5; then lightseq=6'b001100 for 1 cycle -> wait1=0 and D1=0 after the next edge.
REQ-029 Twenty clean sense2 pulses with G2=0 -> wait2 saturates at 15 and does not wrap to 0.
REQ-030 Arrival pulse and lightseq[0]=1 in the same cycle -> wait2=0 and D2=0; a sense2 arrival while lightseq=6'b100001 -> no increment.
REQ-031 wait1=3, then reset=0 for 2 cycles with sense1 held high -> all outputs 0 immediately; after release, wait1=1 after edge 7.
